// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the MEM-stage load/store unit: function codes,
// FSM state encoding and byte-strobe patterns.
package load_store_unit_pkg;

  typedef enum logic [2:0] {
    MEM_LB  = 3'd0,
    MEM_LH  = 3'd1,
    MEM_LW  = 3'd2,
    MEM_SB  = 3'd3,
    MEM_LBU = 3'd4,
    MEM_LHU = 3'd5,
    MEM_SH  = 3'd6,
    MEM_SW  = 3'd7
  } mem_fn_e;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  localparam logic [3:0] LSU_STRB_NONE = 4'b0000;
  localparam logic [3:0] LSU_STRB_BYTE = 4'b0001;
  localparam logic [3:0] LSU_STRB_HALF = 4'b0011;
  localparam logic [3:0] LSU_STRB_WORD = 4'b1111;

  function automatic logic is_store(input logic [2:0] fn);
    return (fn == MEM_SB) || (fn == MEM_SH) || (fn == MEM_SW);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store strobes/replicated data, load byte/half
// extraction with sign or zero extension, and the misalignment check.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  fn,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  wstrb,
  output logic [31:0] bus_wdata,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    wstrb      = LSU_STRB_NONE;
    bus_wdata  = wdata;
    load_data  = rdata;
    misaligned = 1'b0;
    byte_sel   = rdata[{addr, 3'b000} +: 8];
    half_sel   = rdata[{addr[1], 4'b0000} +: 16];
    case (fn)
      MEM_LB:  load_data = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: load_data = {24'd0, byte_sel};
      MEM_LH: begin
        misaligned = addr[0];
        load_data  = {{16{half_sel[15]}}, half_sel};
      end
      MEM_LHU: begin
        misaligned = addr[0];
        load_data  = {16'd0, half_sel};
      end
      MEM_LW:  misaligned = (addr != 2'b00);
      MEM_SB: begin
        wstrb     = LSU_STRB_BYTE << addr;
        bus_wdata = {4{wdata[7:0]}};
      end
      MEM_SH: begin
        misaligned = addr[0];
        wstrb      = LSU_STRB_HALF << {addr[1], 1'b0};
        bus_wdata  = {2{wdata[15:0]}};
      end
      MEM_SW: begin
        misaligned = (addr != 2'b00);
        wstrb      = LSU_STRB_WORD;
      end
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: turns EX/MEM memory ops into valid/ready bus
// transactions, stalls the pipeline until completion, and aborts on timeout.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int DATA_LEN       = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [2:0]          in_mem_fn,
  input  logic [DATA_LEN-1:0] in_addr,
  input  logic [DATA_LEN-1:0] in_wdata,
  output logic                stall,
  output logic                out_valid,
  output logic [DATA_LEN-1:0] out_rdata,
  output logic                misaligned,
  output logic                bus_err,
  output logic                bus_req,
  output logic                bus_we,
  output logic [DATA_LEN-1:0] bus_addr,
  output logic [DATA_LEN-1:0] bus_wdata,
  output logic [3:0]          bus_wstrb,
  input  logic                bus_ready,
  input  logic                bus_rvalid,
  input  logic [DATA_LEN-1:0] bus_rdata
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  lsu_state_e          state_q, state_d;
  logic [2:0]          fn_q;
  logic [DATA_LEN-1:0] addr_q;
  logic [DATA_LEN-1:0] wdata_q;
  logic [3:0]          wstrb_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                err_q;
  logic [DATA_LEN-1:0] rdata_q;

  logic                in_idle;
  logic [2:0]          al_fn;
  logic [1:0]          al_addr;
  logic [3:0]          al_wstrb;
  logic [DATA_LEN-1:0] al_wdata;
  logic [DATA_LEN-1:0] al_load;
  logic                al_misaligned;
  logic                timeout;
  logic                abort;

  // In IDLE the aligner looks at the incoming op; afterwards at the latched one.
  assign in_idle = (state_q == LSU_IDLE);
  assign al_fn   = in_idle ? in_mem_fn    : fn_q;
  assign al_addr = in_idle ? in_addr[1:0] : addr_q[1:0];
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  lsu_align u_align (
    .fn         (al_fn),
    .addr       (al_addr),
    .wdata      (in_wdata),
    .rdata      (bus_rdata),
    .wstrb      (al_wstrb),
    .bus_wdata  (al_wdata),
    .load_data  (al_load),
    .misaligned (al_misaligned)
  );

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    bus_req    = 1'b0;
    out_valid  = 1'b0;
    misaligned = 1'b0;
    abort      = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        if (in_valid) begin
          if (al_misaligned) begin
            misaligned = 1'b1;
          end else begin
            stall   = 1'b1;
            state_d = LSU_REQ;
          end
        end
      end
      LSU_REQ: begin
        stall   = 1'b1;
        bus_req = 1'b1;
        // A handshake in the final cycle still counts; timeout only if idle.
        if (bus_ready) begin
          state_d = is_store(fn_q) ? LSU_DONE : LSU_WAIT;
        end else if (timeout) begin
          abort   = 1'b1;
          state_d = LSU_DONE;
        end
      end
      LSU_WAIT: begin
        stall = 1'b1;
        if (bus_rvalid) begin
          state_d = LSU_DONE;
        end else if (timeout) begin
          abort   = 1'b1;
          state_d = LSU_DONE;
        end
      end
      LSU_DONE: begin
        out_valid = 1'b1;
        state_d   = LSU_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LSU_IDLE;
      fn_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_idle && (state_d == LSU_REQ)) begin
        fn_q    <= in_mem_fn;
        addr_q  <= in_addr;
        wdata_q <= al_wdata;
        wstrb_q <= al_wstrb;
        cnt_q   <= '0;
        err_q   <= 1'b0;
      end
      if ((state_q == LSU_REQ) || (state_q == LSU_WAIT)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if ((state_q == LSU_WAIT) && bus_rvalid) begin
        rdata_q <= al_load;
      end
      if (abort) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  assign bus_we    = bus_req && is_store(fn_q);
  assign bus_wstrb = bus_req ? wstrb_q : LSU_STRB_NONE;
  assign bus_addr  = {addr_q[DATA_LEN-1:2], 2'b00};
  assign bus_wdata = wdata_q;
  assign out_rdata = rdata_q;
  assign bus_err   = (state_q == LSU_DONE) && err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: byte-level reference memory, a
// variable-latency bus responder, and a monitor comparing completions.
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  localparam int TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [2:0]  in_mem_fn;
  logic [31:0] in_addr, in_wdata;
  logic        stall, out_valid, misaligned, bus_err;
  logic [31:0] out_rdata;
  logic        bus_req, bus_we, bus_ready, bus_rvalid;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_wstrb;

  load_store_unit #(.DATA_LEN(32), .TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_mem_fn(in_mem_fn),
    .in_addr(in_addr), .in_wdata(in_wdata), .stall(stall), .out_valid(out_valid),
    .out_rdata(out_rdata), .misaligned(misaligned), .bus_err(bus_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_ready(bus_ready), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_exp_t;

  typedef struct {
    bit          mis;
    bit          err;
    logic [31:0] rdata;
    int          stall;
  } out_exp_t;

  bus_exp_t    bus_q[$];
  out_exp_t    out_q[$];
  logic [31:0] mem_dev [logic [31:0]];
  logic [7:0]  ref_bytes [logic [31:0]];

  int          test_count = 0;
  int          fail_count = 0;
  int          ready_delay, rvalid_delay;
  bit          bus_dead;
  int          done_cnt = 0;
  int          req_cycles = 0;
  int          stall_cnt = 0;
  logic [31:0] last_load;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] w);
    return (w * 32'h9E3779B1) | 32'h0000_0101;
  endfunction

  function automatic logic [31:0] dev_read(input logic [31:0] w);
    return mem_dev.exists(w) ? mem_dev[w] : init_word(w);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    if (ref_bytes.exists(a)) return ref_bytes[a];
    w = init_word(a >> 2);
    return 8'(w >> (8 * (a % 4)));
  endfunction

  function automatic int access_size(input logic [2:0] fn);
    case (fn)
      MEM_LB, MEM_LBU, MEM_SB: return 1;
      MEM_LH, MEM_LHU, MEM_SH: return 2;
      default:                 return 4;
    endcase
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] fn, input logic [31:0] addr);
    int          size;
    logic [31:0] val;
    size = access_size(fn);
    val  = 0;
    for (int i = 0; i < size; i++) val |= 32'(ref_byte(addr + i)) << (8 * i);
    if ((fn == MEM_LB || fn == MEM_LH) && ((val >> (8 * size - 1)) & 1) == 1)
      val |= ~((32'h1 << (8 * size)) - 1);
    return val;
  endfunction

  task automatic preload(input logic [31:0] addr, input logic [31:0] word);
    mem_dev[addr >> 2] = word;
    for (int i = 0; i < 4; i++) ref_bytes[(addr & ~32'h3) + i] = 8'(word >> (8 * i));
  endtask

  // Bus device: waits ready_delay cycles before accepting, returns reads rvalid_delay cycles later.
  initial begin
    int          wait_cnt, rd_left;
    bit          rd_pend;
    logic [31:0] rd_word, w;
    bus_exp_t    b;
    wait_cnt = 0; rd_left = 0; rd_pend = 0; rd_word = 0;
    bus_ready = 0; bus_rvalid = 0; bus_rdata = 0;
    forever begin
      @(negedge clk);
      bus_ready  = 0;
      bus_rvalid = 0;
      if (!bus_req) wait_cnt = 0;
      if (rd_pend) begin
        rd_left--;
        if (rd_left <= 0) begin
          bus_rvalid = 1;
          bus_rdata  = rd_word;
          rd_pend    = 0;
        end
      end else if (bus_req && !bus_dead) begin
        if (wait_cnt < ready_delay) begin
          wait_cnt++;
        end else begin
          wait_cnt  = 0;
          bus_ready = 1;
          if (bus_q.size() == 0) begin
            checkOutput("unexpected_bus_req", 1, 0);
          end else begin
            b = bus_q.pop_front();
            checkOutput("bus_addr", bus_addr, b.addr);
            checkOutput("bus_we", 32'(bus_we), 32'(b.we));
            checkOutput("bus_wstrb", 32'(bus_wstrb), 32'(b.wstrb));
            if (b.we) checkOutput("bus_wdata", bus_wdata, b.wdata);
          end
          if (bus_we) begin
            w = dev_read(bus_addr >> 2);
            for (int l = 0; l < 4; l++)
              if (bus_wstrb[l]) w[8*l +: 8] = bus_wdata[8*l +: 8];
            mem_dev[bus_addr >> 2] = w;
          end else begin
            rd_pend = 1;
            rd_left = rvalid_delay;
            rd_word = dev_read(bus_addr >> 2);
          end
        end
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes or flags a misaligned op.
  always @(negedge clk) begin
    out_exp_t e;
    if (!reset) begin
      stall_cnt = 0;
    end else begin
      if (bus_req) req_cycles++;
      if (stall) stall_cnt++;
      if (out_valid || misaligned) begin
        if (out_q.size() == 0) begin
          checkOutput("unexpected_completion", 1, 0);
        end else begin
          e = out_q.pop_front();
          checkOutput("misaligned_flag", 32'(misaligned), 32'(e.mis));
          if (e.mis) begin
            checkOutput("stall_on_misaligned", 32'(stall), 0);
            checkOutput("out_valid_on_misaligned", 32'(out_valid), 0);
          end else begin
            checkOutput("bus_err", 32'(bus_err), 32'(e.err));
            checkOutput("out_rdata", out_rdata, e.rdata);
            checkOutput("stall_cycles", stall_cnt, e.stall);
            stall_cnt = 0;
          end
        end
        if (out_valid) done_cnt++;
      end
    end
  end

  // Issue one op from the EX/MEM side; expects to be called at posedge+2.
  task automatic applyStimulus(input logic [2:0] fn, input logic [31:0] addr, input logic [31:0] wdata);
    out_exp_t e;
    bus_exp_t b;
    int       size, n, c, req0;
    bit       st;
    size = access_size(fn);
    st   = (fn == MEM_SB || fn == MEM_SH || fn == MEM_SW);
    e.mis = 0; e.err = 0; e.rdata = last_load; e.stall = 0;
    in_mem_fn = fn; in_addr = addr; in_wdata = wdata;
    if ((addr % size) != 0) begin
      e.mis = 1;
      out_q.push_back(e);
      req0 = req_cycles;
      in_valid = 1;
      @(posedge clk); #2;
      in_valid = 0;
      @(posedge clk); #2;
      checkOutput("misaligned_no_bus_req", req_cycles, req0);
      return;
    end
    b.addr = addr & ~32'h3;
    b.we   = st;
    b.wstrb = 0;
    b.wdata = 0;
    if (st) begin
      for (int i = 0; i < size; i++) b.wstrb[(addr % 4) + i] = 1'b1;
      for (int l = 0; l < 4; l++) b.wdata[8*l +: 8] = 8'(wdata >> (8 * (l % size)));
      for (int i = 0; i < size; i++) ref_bytes[addr + i] = 8'(wdata >> (8 * i));
    end else begin
      e.rdata   = ref_load(fn, addr);
      last_load = e.rdata;
    end
    if (bus_dead) begin
      e.err = 1; e.rdata = 0; last_load = 0;
      e.stall = 1 + TIMEOUT;
    end else begin
      bus_q.push_back(b);
      e.stall = 1 + (ready_delay + 1) + (st ? 0 : rvalid_delay);
    end
    out_q.push_back(e);
    n = done_cnt;
    c = 0;
    in_valid = 1;
    while (done_cnt == n && c < TIMEOUT + 100) begin
      @(posedge clk);
      c++;
    end
    checkOutput("op_completed", done_cnt - n, 1);
    #2;
    in_valid = 0;
  endtask

  initial begin
    reset = 0; in_valid = 0; in_mem_fn = 0; in_addr = 0; in_wdata = 0;
    ready_delay = 0; rvalid_delay = 1; bus_dead = 0; last_load = 0;
    #3;
    checkOutput("rst_stall", 32'(stall), 0);
    checkOutput("rst_out_valid", 32'(out_valid), 0);
    checkOutput("rst_out_rdata", out_rdata, 0);
    checkOutput("rst_bus_req", 32'(bus_req), 0);
    checkOutput("rst_bus_addr", bus_addr, 0);
    checkOutput("rst_bus_wstrb", 32'(bus_wstrb), 0);
    checkOutput("rst_bus_err", 32'(bus_err), 0);
    repeat (3) @(posedge clk);
    #2; reset = 1;
    @(posedge clk); #2;

    applyStimulus(MEM_SB, 32'h103, 32'h0000_00A5);

    preload(32'h200, 32'h8001_1234);
    rvalid_delay = 3;
    applyStimulus(MEM_LH, 32'h202, 32'h0);
    applyStimulus(MEM_LHU, 32'h202, 32'h0);

    rvalid_delay = 1;
    applyStimulus(MEM_LW, 32'h106, 32'h0);
    applyStimulus(MEM_LW, 32'h104, 32'h0);

    // Reset while the load sits in WAIT; the late response must be ignored.
    rvalid_delay = 6;
    bus_q.push_back('{addr: 32'h300, we: 1'b0, wstrb: 4'b0000, wdata: 32'h0});
    in_mem_fn = MEM_LW; in_addr = 32'h300; in_wdata = 0; in_valid = 1;
    repeat (3) @(posedge clk);
    #2; reset = 0; in_valid = 0;
    #1;
    checkOutput("midop_rst_stall", 32'(stall), 0);
    checkOutput("midop_rst_bus_req", 32'(bus_req), 0);
    checkOutput("midop_rst_out_rdata", out_rdata, 0);
    repeat (8) @(posedge clk);
    checkOutput("rst_rdata_after_late_rvalid", out_rdata, 0);
    #2; reset = 1; last_load = 0;
    rvalid_delay = 1;
    applyStimulus(MEM_SW, 32'h300, 32'hCAFE_F00D);
    applyStimulus(MEM_LW, 32'h300, 32'h0);

    rvalid_delay = 2;
    applyStimulus(MEM_SW, 32'h400, 32'h1234_56A5);
    applyStimulus(MEM_LB, 32'h400, 32'h0);

    bus_dead = 1;
    applyStimulus(MEM_LB, 32'h500, 32'h0);
    bus_dead = 0;
    applyStimulus(MEM_LBU, 32'h403, 32'h0);

    for (int k = 0; k < 60; k++) begin
      ready_delay  = $urandom_range(0, 3);
      rvalid_delay = $urandom_range(1, 3);
      applyStimulus(3'($urandom_range(0, 7)), 32'h1000 + $urandom_range(0, 31), $urandom);
    end

    repeat (3) @(posedge clk);
    checkOutput("scoreboard_drained", out_q.size() + bus_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- MEM-stage access unit between the EX/MEM pipeline register and a data memory with a valid/ready handshake and variable latency.
- Converts mem_fn/addr/rs2 data into word-aligned bus transactions with byte strobes, stalls the pipeline until the access completes, and aligns and extends load data for MEM/WB.
- Flags misaligned accesses and bus timeouts.

Parameters:
- DATA_LEN, 32, data/address width.
- TIMEOUT_CYCLES, 255, cycles in REQ+WAIT before the access is aborted with bus_err.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- in_valid  in  1  EX/MEM holds a memory op
- in_mem_fn  in  3  MEM_LB/LH/LW/LBU/LHU/SB/SH/SW from define.vh
- in_addr  in  32  byte address (ex_mem_alu_out)
- in_wdata  in  32  store data (ex_mem_rs2_data)
- stall  out  1  freeze IF..EX/MEM
- out_valid  out  1  access complete; loads have out_rdata valid
- out_rdata  out  32  aligned, extended load data
- misaligned  out  1  misaligned op dropped
- bus_err  out  1  access aborted on timeout
- bus_req  out  1  request valid
- bus_we  out  1  1 = write
- bus_addr  out  32  {in_addr[31:2],2'b00}
- bus_wdata  out  32  lane-replicated store data
- bus_wstrb  out  4  byte enables (0 for reads)
- bus_ready  in  1  request accepted this cycle
- bus_rvalid  in  1  read data valid
- bus_rdata  in  32  read word

Behaviour:
- Reset: async, active-low. State is IDLE. All outputs and registered fields are 0. Takes effect immediately mid-op. bus_req drops at once. A late bus_rvalid after reset is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - in_valid and aligned: latch fn, addr, wdata; clear timeout counter; go to REQ.
  - stall=1 combinationally in this cycle.
- Misaligned access: LW/SW with addr[1:0]!=0; LH/LHU/SH with addr[0]!=0.
  - In IDLE, misaligned=1 combinationally; stall=0; no bus access; state stays IDLE.
- REQ:
  - bus_req=1; addr, we, wdata and wstrb are held stable until bus_ready.
  - On bus_ready: a store goes to DONE; a load goes to WAIT.
  - bus_rvalid in REQ is ignored; the first valid response is at least 1 cycle after accept.
- WAIT: on bus_rvalid, register the aligned data into out_rdata and go to DONE.
- DONE:
  - stall=0; out_valid=1 for one cycle; the pipeline advances on this edge.
  - in_valid is ignored in DONE. Next state is IDLE.
- stall = (IDLE and in_valid and aligned) or REQ or WAIT.
- Timeout:
  - The counter increments every cycle in REQ/WAIT.
  - On reaching TIMEOUT_CYCLES: drop bus_req, go to DONE with bus_err=1, out_valid=1, out_rdata=0.
  - bus_ready or bus_rvalid in the same cycle as the timeout wins over the timeout.
- Store strobes and data:
  - SB: wstrb=4'b0001<<addr[1:0]; wdata={4{b}}.
  - SH: wstrb=4'b0011<<{addr[1],1'b0}; wdata={2{h}}.
  - SW: wstrb=4'b1111; wdata as given.
- Load alignment: byte = rdata[8*addr[1:0]+:8]; half = rdata[16*addr[1]+:16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
  - out_rdata holds its value until the next load completes.
- Minimum latency:
  - Store with immediate ready: 2 stall cycles.
  - Load with ready at once and rvalid the next cycle: 3 stall cycles.

Decomposition:
- define.vh: MEM_* fn codes; new LSU_IDLE/REQ/WAIT/DONE state codes; LSU_STRB_* constants.
- One combinational sub-module, lsu_align:
  - Inputs: fn, addr[1:0], wdata, rdata.
  - Outputs: wstrb, bus_wdata, load result, misaligned.
- The FSM and timeout counter stay in load_store_unit.

Test Plan:
- SB addr=0x103 data=0x000000A5, ready immediate -> bus_addr=0x100, wstrb=4'b1000, wdata=0xA5A5A5A5, stall high 2 cycles, out_valid one cycle.
- LH addr=0x202, rdata=0x8001_1234, rvalid 3 cycles after accept -> out_rdata=0xFFFF8001; LHU -> 0x00008001; stall high 5 cycles.
- LW addr=0x106 -> misaligned=1, stall=0, bus_req never asserted; then LW 0x104 completes normally.
- Load with bus_ready held low 255 cycles -> bus_err=1, out_valid=1, out_rdata=0, state returns to IDLE.
- reset low while in WAIT, then rvalid arrives -> outputs 0 at once, response ignored, next SW proceeds normally.
- Back-to-back SW then LB at same addr with 2-cycle-latency memory model -> LB returns the stored byte sign-extended (0xA5 -> 0xFFFFFFA5).
